// File: rtl/sw_pkg.sv
// Shared types and widths for the reference-sequence reader and its block buffer.
package sw_pkg;

  localparam int ADDR_W          = 25;
  localparam int LEN_W           = 25;
  localparam int REF_LENGTH_DFLT = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Block addresses wrap modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 25'd1;
  endfunction

endpackage

// File: rtl/ref_block_fifo.sv
// Synchronous first-word-fall-through block buffer with an occupancy count.
module ref_block_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && (count_r != CW'(DEPTH));
  assign do_pop_s  = pop && (count_r != {CW{1'b0}});

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      if (do_push_s && !do_pop_s)      count_r <= count_r + CW'(1'b1);
      else if (!do_push_s && do_pop_s) count_r <= count_r - CW'(1'b1);
      else                             count_r <= count_r;
    end
  end

  // Storage array carries no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s) mem[wr_ptr_r] <= push_data;
  end

  assign pop_data = mem[rd_ptr_r];
  assign valid    = (count_r != {CW{1'b0}});
  assign count    = count_r;

endmodule

// File: rtl/ref_seq_reader.sv
// Streams a run of reference blocks from DRAM into the engine, issuing reads only
// while the block buffer has room for every read already in flight.
module ref_seq_reader
  import sw_pkg::*;
#(
  parameter int REF_LENGTH = REF_LENGTH_DFLT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       ref_addr_in,
  input  logic [LEN_W-1:0]        ref_length_in,
  input  logic                    ref_info_valid_in,
  output logic                    busy_out,
  output logic [ADDR_W-1:0]       dram_rd_addr_out,
  output logic                    dram_rd_valid_out,
  input  logic                    dram_rd_rdy_in,
  input  logic [2*REF_LENGTH-1:0] dram_rd_data_in,
  input  logic                    dram_rd_data_valid_in,
  output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
  output logic                    ref_seq_block_valid_out,
  input  logic                    ref_seq_block_rdy_in,
  output logic                    spurious_rsp_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic [LEN_W-1:0]  remaining_r, rem_next_s;
  logic [CW-1:0]     outstanding_r, out_next_s;
  logic [CW-1:0]     fifo_count_s, cnt_next_s;
  logic              rd_valid_r, busy_r, spurious_r;
  logic              rd_hs_s, rsp_ok_s, rsp_bad_s, pop_s, fifo_valid_s;
  logic              credit_s, rd_valid_next_s;

  assign rd_hs_s   = rd_valid_r && dram_rd_rdy_in;
  assign rsp_ok_s  = dram_rd_data_valid_in && (outstanding_r != {CW{1'b0}});
  assign rsp_bad_s = dram_rd_data_valid_in && (outstanding_r == {CW{1'b0}});
  assign pop_s     = fifo_valid_s && ref_seq_block_rdy_in;

  ref_block_fifo #(.WIDTH(2*REF_LENGTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_ok_s),
    .push_data (dram_rd_data_in),
    .pop       (pop_s),
    .pop_data  (ref_seq_block_out),
    .valid     (fifo_valid_s),
    .count     (fifo_count_s)
  );

  // Post-edge in-flight read count and buffer occupancy used for the credit check.
  always_comb begin
    out_next_s = outstanding_r;
    cnt_next_s = fifo_count_s;
    if (rd_hs_s && !rsp_ok_s)      out_next_s = outstanding_r + CW'(1'b1);
    else if (!rd_hs_s && rsp_ok_s) out_next_s = outstanding_r - CW'(1'b1);
    else                           out_next_s = outstanding_r;
    if (rsp_ok_s && !pop_s)        cnt_next_s = fifo_count_s + CW'(1'b1);
    else if (!rsp_ok_s && pop_s)   cnt_next_s = fifo_count_s - CW'(1'b1);
    else                           cnt_next_s = fifo_count_s;
  end

  // Request sequencing: accept, issue reads, then wait for the buffer to drain.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    rem_next_s   = remaining_r;
    case (state_r)
      IDLE: begin
        if (ref_info_valid_in && (ref_length_in != 25'd0)) begin
          state_next_s = ISSUE;
          addr_next_s  = ref_addr_in;
          rem_next_s   = ref_length_in;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (rd_hs_s) begin
          addr_next_s  = next_addr(addr_r);
          rem_next_s   = remaining_r - 25'd1;
          state_next_s = (remaining_r == 25'd1) ? DRAIN : ISSUE;
        end else begin
          state_next_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((out_next_s == {CW{1'b0}}) && (cnt_next_s == {CW{1'b0}})) state_next_s = IDLE;
        else                                                          state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // A pending command holds until accepted; a new one needs a free buffer slot.
  assign credit_s        = (int'(out_next_s) + int'(cnt_next_s)) < FIFO_DEPTH;
  assign rd_valid_next_s = (rd_valid_r && !rd_hs_s) ||
                           ((state_next_s == ISSUE) && (rem_next_s != 25'd0) && credit_s);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      addr_r        <= 25'd0;
      remaining_r   <= 25'd0;
      outstanding_r <= {CW{1'b0}};
      rd_valid_r    <= 1'b0;
      busy_r        <= 1'b0;
      spurious_r    <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      addr_r        <= addr_next_s;
      remaining_r   <= rem_next_s;
      outstanding_r <= out_next_s;
      rd_valid_r    <= rd_valid_next_s;
      busy_r        <= (state_next_s != IDLE);
      spurious_r    <= spurious_r || rsp_bad_s;
    end
  end

  assign busy_out                = busy_r;
  assign dram_rd_addr_out        = addr_r;
  assign dram_rd_valid_out       = rd_valid_r;
  assign ref_seq_block_valid_out = fifo_valid_s;
  assign spurious_rsp_out        = spurious_r;

endmodule

// File: tb/tb_ref_seq_reader.sv
// Scenario bench for ref_seq_reader: a DRAM model answers reads in order and the
// expected read addresses and block contents are derived from each request.
module tb_ref_seq_reader;

  localparam int RL = 128;
  localparam int FD = 8;
  localparam int DW = 2 * RL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [24:0]   ref_addr_in = 25'd0;
  logic [24:0]   ref_length_in = 25'd0;
  logic          ref_info_valid_in = 1'b0;
  logic          busy_out;
  logic [24:0]   dram_rd_addr_out;
  logic          dram_rd_valid_out;
  logic          dram_rd_rdy_in = 1'b0;
  logic [DW-1:0] dram_rd_data_in = {DW{1'b0}};
  logic          dram_rd_data_valid_in = 1'b0;
  logic [DW-1:0] ref_seq_block_out;
  logic          ref_seq_block_valid_out;
  logic          ref_seq_block_rdy_in = 1'b0;
  logic          spurious_rsp_out;

  always #5 clk = ~clk;

  ref_seq_reader #(.REF_LENGTH(RL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .ref_addr_in(ref_addr_in), .ref_length_in(ref_length_in), .ref_info_valid_in(ref_info_valid_in),
    .busy_out(busy_out),
    .dram_rd_addr_out(dram_rd_addr_out), .dram_rd_valid_out(dram_rd_valid_out), .dram_rd_rdy_in(dram_rd_rdy_in),
    .dram_rd_data_in(dram_rd_data_in), .dram_rd_data_valid_in(dram_rd_data_valid_in),
    .ref_seq_block_out(ref_seq_block_out), .ref_seq_block_valid_out(ref_seq_block_valid_out),
    .ref_seq_block_rdy_in(ref_seq_block_rdy_in),
    .spurious_rsp_out(spurious_rsp_out)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int lat = 3;
  int issued = 0;
  int popped = 0;
  int model_fifo = 0;
  bit drop_rsp = 1'b0;
  bit last_pop = 1'b0;
  bit prev_hold = 1'b0;
  logic [24:0] prev_addr = 25'd0;
  logic [24:0] exp_rd[$];
  logic [24:0] exp_blk[$];
  logic [24:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [DW-1:0] data_of(input logic [24:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = {7'd0, a} * 32'h9E3779B1 + 32'(k);
    return d;
  endfunction

  // One clock: account for handshakes seen before the edge, then let the DRAM model respond.
  task automatic tick();
    logic [24:0] e;
    last_pop = 1'b0;
    if (prev_hold) begin
      n_checks++;
      if (dram_rd_valid_out !== 1'b1 || dram_rd_addr_out !== prev_addr) begin
        n_fail++;
        $display("FAIL cmd_hold: valid=%b addr=%h, required valid=1 addr=%h", dram_rd_valid_out, dram_rd_addr_out, prev_addr);
      end
    end
    prev_hold = dram_rd_valid_out && !dram_rd_rdy_in;
    prev_addr = dram_rd_addr_out;
    if (dram_rd_valid_out && dram_rd_rdy_in) begin
      n_checks++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL rd_addr: unexpected read of %h, required none", dram_rd_addr_out);
      end else begin
        e = exp_rd.pop_front();
        if (dram_rd_addr_out !== e) begin
          n_fail++;
          $display("FAIL rd_addr: got %h, required %h", dram_rd_addr_out, e);
        end
      end
      n_checks++;
      if (issued - popped >= FD) begin
        n_fail++;
        $display("FAIL credit: read issued with %0d blocks in flight, required < %0d", issued - popped, FD);
      end
      issued++;
      pend_addr.push_back(dram_rd_addr_out);
      pend_due.push_back(cycle + lat);
    end
    if (ref_seq_block_valid_out && ref_seq_block_rdy_in) begin
      n_checks++;
      if (exp_blk.size() == 0) begin
        n_fail++;
        $display("FAIL blk_data: unexpected block %h, required none", ref_seq_block_out[31:0]);
      end else begin
        e = exp_blk.pop_front();
        if (ref_seq_block_out !== data_of(e)) begin
          n_fail++;
          $display("FAIL blk_data: got %h, required block of addr %h (%h)", ref_seq_block_out, e, data_of(e));
        end
      end
      popped++;
      model_fifo--;
      last_pop = 1'b1;
    end
    if (dram_rd_data_valid_in && !drop_rsp) model_fifo++;
    @(posedge clk);
    #1;
    cycle++;
    if (pend_due.size() != 0 && pend_due[0] <= cycle) begin
      dram_rd_data_valid_in = 1'b1;
      dram_rd_data_in = data_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      dram_rd_data_valid_in = 1'b0;
      dram_rd_data_in = {DW{1'b0}};
    end
  endtask

  task automatic request(input logic [24:0] a, input logic [24:0] len, input bit accept);
    logic [24:0] t;
    ref_addr_in = a;
    ref_length_in = len;
    ref_info_valid_in = 1'b1;
    if (accept) begin
      for (int i = 0; i < int'(len); i++) begin
        t = a + 25'(i);
        exp_rd.push_back(t);
        exp_blk.push_back(t);
      end
    end
    tick();
    ref_info_valid_in = 1'b0;
  endtask

  // Run until the transfer is fully delivered, checking busy drops with the final pop.
  task automatic run_until_idle(input int max, input int p_drdy, input int p_brdy, input string nm);
    int n = 0;
    while ((busy_out || exp_blk.size() != 0 || pend_due.size() != 0) && n < max) begin
      dram_rd_rdy_in = ($urandom_range(99) < p_drdy);
      ref_seq_block_rdy_in = ($urandom_range(99) < p_brdy);
      tick();
      n++;
      if (last_pop && exp_blk.size() == 0) begin
        n_checks++;
        if (busy_out !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy_fall: busy=%b after last pop, required 0", nm, busy_out);
        end
      end
    end
    n_checks++;
    if (n >= max) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d blocks still pending after %0d cycles, required 0", nm, exp_blk.size(), max);
    end
    dram_rd_rdy_in = 1'b1;
    ref_seq_block_rdy_in = 1'b1;
  endtask

  task automatic clear_counts();
    issued = 0;
    popped = 0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy_out, dram_rd_valid_out, ref_seq_block_valid_out, spurious_rsp_out, dram_rd_addr_out} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rdv=%b bv=%b sp=%b addr=%h, required all 0",
               busy_out, dram_rd_valid_out, ref_seq_block_valid_out, spurious_rsp_out, dram_rd_addr_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dram_rd_rdy_in = 1'b1;
    ref_seq_block_rdy_in = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (busy_out !== 1'b0 || dram_rd_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b rdv=%b, required 0 0", busy_out, dram_rd_valid_out);
    end
  endtask

  task automatic test_basic();
    int base;
    clear_counts();
    lat = 3;
    request(25'h100, 25'd4, 1'b1);
    n_checks++;
    if (busy_out !== 1'b1 || dram_rd_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_first_read: busy=%b rdv=%b one cycle after accept, required 1 1", busy_out, dram_rd_valid_out);
    end
    base = issued;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (issued != base + i + 1) begin
        n_fail++;
        $display("FAIL basic_consecutive: %0d reads after %0d cycles, required %0d", issued - base, i + 1, i + 1);
      end
    end
    run_until_idle(200, 100, 100, "basic");
    n_checks++;
    if (popped != 4 || exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL basic_count: popped=%0d reads_left=%0d, required 4 0", popped, exp_rd.size());
    end
  endtask

  task automatic test_backpressure();
    clear_counts();
    lat = 2;
    ref_seq_block_rdy_in = 1'b0;
    request(25'h1000, 25'd20, 1'b1);
    repeat (40) tick();
    n_checks++;
    if (issued != FD || dram_rd_valid_out !== 1'b0 || ref_seq_block_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: reads=%0d rdv=%b bv=%b, required %0d 0 1", issued, dram_rd_valid_out, ref_seq_block_valid_out, FD);
    end
    run_until_idle(500, 100, 100, "bp");
    n_checks++;
    if (popped != 20 || issued != 20) begin
      n_fail++;
      $display("FAIL bp_count: popped=%0d reads=%0d, required 20 20", popped, issued);
    end
  endtask

  task automatic test_wrap();
    clear_counts();
    lat = 3;
    request(25'h1FFFFFE, 25'd3, 1'b1);
    run_until_idle(200, 100, 100, "wrap");
    n_checks++;
    if (popped != 3 || exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_count: popped=%0d reads_left=%0d, required 3 0", popped, exp_rd.size());
    end
  endtask

  task automatic test_ignore();
    clear_counts();
    lat = 2;
    request(25'h50, 25'd0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (busy_out !== 1'b0 || dram_rd_valid_out !== 1'b0 || issued != 0) begin
      n_fail++;
      $display("FAIL ignore_len0: busy=%b rdv=%b reads=%0d, required 0 0 0", busy_out, dram_rd_valid_out, issued);
    end
    request(25'h40, 25'd5, 1'b1);
    tick();
    tick();
    request(25'h999, 25'd7, 1'b0);
    run_until_idle(300, 100, 100, "ignore");
    n_checks++;
    if (popped != 5 || issued != 5) begin
      n_fail++;
      $display("FAIL ignore_busy_req: popped=%0d reads=%0d, required 5 5", popped, issued);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    clear_counts();
    lat = 20;
    request(25'h200, 25'd6, 1'b1);
    while (issued < 2 && n < 20) begin
      tick();
      n++;
    end
    dram_rd_rdy_in = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy_out, dram_rd_valid_out, ref_seq_block_valid_out, spurious_rsp_out, dram_rd_addr_out} !== 29'd0 || issued != 2) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b rdv=%b bv=%b sp=%b addr=%h reads=%0d, required all 0 with 2 reads",
               busy_out, dram_rd_valid_out, ref_seq_block_valid_out, spurious_rsp_out, dram_rd_addr_out, issued);
    end
    prev_hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle++;
    exp_rd.delete();
    exp_blk.delete();
    while (pend_due.size() > 1) begin
      void'(pend_due.pop_back());
      void'(pend_addr.pop_back());
    end
    drop_rsp = 1'b1;
    clear_counts();
    model_fifo = 0;
    dram_rd_rdy_in = 1'b1;
    ref_seq_block_rdy_in = 1'b1;
    repeat (30) tick();
    n_checks++;
    if (spurious_rsp_out !== 1'b1 || ref_seq_block_valid_out !== 1'b0 || busy_out !== 1'b0 || popped != 0) begin
      n_fail++;
      $display("FAIL midrst_late_rsp: sp=%b bv=%b busy=%b popped=%0d, required 1 0 0 0",
               spurious_rsp_out, ref_seq_block_valid_out, busy_out, popped);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (spurious_rsp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_clear: sp=%b in reset, required 0", spurious_rsp_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle++;
    drop_rsp = 1'b0;
    model_fifo = 0;
  endtask

  // Hold the consumer off until the buffer sits at the target level with a response arriving, then pop once.
  task automatic push_pop_at(input int level);
    int n = 0;
    ref_seq_block_rdy_in = 1'b0;
    while (!(model_fifo == level && dram_rd_data_valid_in && ref_seq_block_valid_out) && n < 60) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 60) begin
      n_fail++;
      $display("FAIL pushpop_setup: level %0d never reached, stuck at %0d", level, model_fifo);
    end
    ref_seq_block_rdy_in = 1'b1;
    tick();
    ref_seq_block_rdy_in = 1'b0;
    n_checks++;
    if (int'(dut.u_fifo.count) != level || model_fifo != level) begin
      n_fail++;
      $display("FAIL pushpop_count: count=%0d, required %0d", dut.u_fifo.count, level);
    end
  endtask

  task automatic test_push_pop();
    clear_counts();
    lat = 1;
    ref_seq_block_rdy_in = 1'b0;
    request(25'h300, 25'd16, 1'b1);
    push_pop_at(1);
    push_pop_at(FD - 1);
    run_until_idle(300, 100, 100, "pushpop");
    n_checks++;
    if (popped != 16) begin
      n_fail++;
      $display("FAIL pushpop_total: popped=%0d, required 16", popped);
    end
  endtask

  task automatic test_random();
    logic [24:0] a;
    int len;
    for (int it = 0; it < 6; it++) begin
      clear_counts();
      lat = $urandom_range(1, 6);
      len = $urandom_range(1, 24);
      a = (it % 2 == 0) ? 25'($urandom) : 25'h1FFFFFF - 25'($urandom_range(0, 10));
      request(a, 25'(len), 1'b1);
      run_until_idle(3000, 70, 60, "random");
      n_checks++;
      if (popped != len || issued != len) begin
        n_fail++;
        $display("FAIL random_count: addr=%h popped=%0d reads=%0d, required %0d", a, popped, issued, len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_ignore();
    test_mid_reset();
    test_push_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ref_seq_reader.md
REF_SEQ_READER -- requirements
Module: ref_seq_reader

Interface
REQ-001 SHALL have parameter REF_LENGTH, default 128: bases per reference block, 2 bits each.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: block buffer entries, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ref_addr_in, input, 25: DRAM block address of the first reference block.
REQ-006 SHALL have port ref_length_in, input, 25: number of blocks to read.
REQ-007 SHALL have port ref_info_valid_in, input, 1: request valid.
REQ-008 SHALL have port busy_out, output, 1: a request is in progress.
REQ-009 SHALL have port dram_rd_addr_out, output, 25: DRAM read address.
REQ-010 SHALL have port dram_rd_valid_out, output, 1: read command valid.
REQ-011 SHALL have port dram_rd_rdy_in, input, 1: read command accepted.
REQ-012 SHALL have port dram_rd_data_in, input, 2*REF_LENGTH: read response data.
REQ-013 SHALL have port dram_rd_data_valid_in, input, 1: response valid; responses arrive in order with no backpressure.
REQ-014 SHALL have port ref_seq_block_out, output, 2*REF_LENGTH: reference block sent to the engine.
REQ-015 SHALL have port ref_seq_block_valid_out, output, 1: block valid.
REQ-016 SHALL have port ref_seq_block_rdy_in, input, 1: block consumed.
REQ-017 SHALL have port spurious_rsp_out, output, 1: sticky flag for a response that had no outstanding read.

Function
REQ-018 SHALL use the states IDLE, ISSUE and DRAIN.
REQ-019 In IDLE, ref_info_valid_in=1 with ref_length_in≠0 SHALL latch the address and length, then go to ISSUE on the next cycle.
REQ-020 In IDLE, ref_info_valid_in=1 with ref_length_in=0 SHALL be ignored, and the block SHALL stay in IDLE.
REQ-021 ref_info_valid_in SHALL be ignored in ISSUE and DRAIN; only one request is outstanding at a time.
REQ-022 busy_out SHALL be 1 exactly when the state is ISSUE or DRAIN.
REQ-023 dram_rd_valid_out SHALL be 1 in ISSUE only when outstanding + fifo_count < FIFO_DEPTH (credit rule), so the FIFO can never overflow.
REQ-024 Once asserted, dram_rd_valid_out and dram_rd_addr_out SHALL hold until dram_rd_valid_out & dram_rd_rdy_in.
REQ-025 On each read handshake, the address SHALL increment by 1, wrapping modulo 2^25 (0x1FFFFFF→0x0000000), and the remaining count SHALL decrement by 1.
REQ-026 The handshake that takes the remaining count to 0 SHALL move the state to DRAIN.
REQ-027 DRAIN SHALL return to IDLE when outstanding=0 and the FIFO is empty, including the cycle of the final pop.
REQ-028 The first dram_rd_valid_out SHALL rise 1 cycle after the request is accepted.
REQ-029 A response on cycle N SHALL make ref_seq_block_valid_out=1 on cycle N+1 when the FIFO was empty (first-word-fall-through).
REQ-030 A pop SHALL occur on ref_seq_block_valid_out & ref_seq_block_rdy_in.
REQ-031 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-032 A pop with ref_seq_block_valid_out=0 SHALL be a no-op.
REQ-033 Outstanding reads SHALL be counted +1 per read handshake and −1 per response; simultaneous events SHALL net to zero.
REQ-034 A response with outstanding=0 SHALL be dropped and SHALL set spurious_rsp_out until reset.
REQ-035 Blocks SHALL reach the output in DRAM address order with data bit-exact.

Reset
REQ-036 Reset assertion SHALL asynchronously force state IDLE and clear the address, remaining count, outstanding count and FIFO pointers.
REQ-037 During reset, busy_out, dram_rd_valid_out, ref_seq_block_valid_out and spurious_rsp_out SHALL be 0, and dram_rd_addr_out SHALL be 0.
REQ-038 Reset mid-transfer SHALL abandon the request.
REQ-039 Responses that arrive after a mid-transfer reset SHALL be dropped per REQ-034.
REQ-040 Reset deassertion SHALL take effect on the next clk edge; no request is accepted on the same edge.

Structure
REQ-041 The state encoding, address/length widths (25) and the REF_LENGTH default SHALL live in the shared package sw_pkg.
REQ-042 The buffer SHALL be a sub-module, ref_block_fifo (synchronous first-word-fall-through FIFO with count output); the state machine and counters SHALL stay in ref_seq_reader.

Verification
REQ-043 Scenario 1: request addr=0x100, len=4, dram_rd_rdy_in=1, 3-cycle response latency, rdy_in=1 -> reads issued to 0x100–0x103 on consecutive cycles, 4 blocks out in order, busy_out falls after the last pop.
REQ-044 Scenario 2: len=20 with ref_seq_block_rdy_in=0 -> exactly 8 reads issued, then dram_rd_valid_out=0; raising rdy_in resumes reads; 20 blocks delivered with none lost.
REQ-045 Scenario 3: addr=0x1FFFFFE, len=3 -> read addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
REQ-046 Scenario 4: len=0 request, then ref_info_valid_in pulsed during a len=5 transfer -> no reads for either; the 5-block transfer completes unchanged.
REQ-047 Scenario 5: rst low for 1 cycle after 2 of 6 reads, then one late response -> all outputs 0 during reset; the late response sets spurious_rsp_out=1 and no block is emitted.
REQ-048 Scenario 6: a push and a pop on the same cycle at fifo_count=1, and at fifo_count=FIFO_DEPTH−1 -> count unchanged and data order preserved.
